// File: rtl/hdmi_video_capture.sv
// HDMI receiver front end: registers the parallel video bus, frames DE pixels into a
// valid/ready stream (SOF/EOL) through a small FWFT FIFO and measures active frame size.
module hdmi_video_capture #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int DIM_W      = 12,
  parameter bit VS_POL     = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] hdmi_data,
  input  logic              hdmi_hs,
  input  logic              hdmi_vs,
  input  logic              hdmi_de,
  input  logic              enable_in,
  output logic [DATA_W-1:0] pix_data_out,
  output logic              pix_sof_out,
  output logic              pix_eol_out,
  output logic              pix_valid_out,
  input  logic              pix_ready_in,
  output logic [DIM_W-1:0]  frame_width_out,
  output logic [DIM_W-1:0]  frame_height_out,
  output logic              frame_info_valid_out,
  output logic [15:0]       overflow_cnt_out,
  output logic              locked_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_W + 2;
  localparam logic [DIM_W-1:0] DIM_MAX = '1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, ACTIVE = 2'd2, DROP = 2'd3} state_e;

  function automatic logic [DIM_W-1:0] sat_inc(input logic [DIM_W-1:0] x);
    return (x == DIM_MAX) ? x : x + 1'b1;
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic              vs_s1_q, vs_s1_d, vs_prev_q, vs_prev_d, de_s1_q, de_s1_d;
  logic              hs_unused_q, hs_unused_d;
  logic              pv_s2_q, pv_s2_d, sof_pend_q, sof_pend_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DIM_W-1:0]  pix_cnt_q, pix_cnt_d, line_w_q, line_w_d, line_cnt_q, line_cnt_d;
  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic              info_q, info_d, locked_q, locked_d, ref_vld_q, ref_vld_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [DIM_W-1:0]  pix_cnt_n, line_w_n, line_cnt_n;

  logic [FW-1:0] fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] head, wr_word;
  logic pv_s1, vs_edge, full, rd_en, wr_try, wr_en, ovf_evt;

  assign pv_s1   = de_s1_q & ~vs_s1_q;
  assign vs_edge = vs_s1_q & ~vs_prev_q;
  assign full    = (cnt_q == CNT_FULL);
  assign rd_en   = pix_valid_out & pix_ready_in;
  assign wr_try  = pv_s2_q & (state_q == ACTIVE);
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en   = wr_try & (~full | rd_en);
  assign ovf_evt = wr_try & full & ~rd_en;
  // The held pixel ends its line when the pixel behind it is not qualified.
  assign wr_word = {sof_pend_q, ~pv_s1, data_s2_q};

  assign head                 = fifo_mem[rd_ptr_q];
  assign pix_valid_out        = (cnt_q != '0);
  assign pix_data_out         = pix_valid_out ? head[DATA_W-1:0] : '0;
  assign pix_eol_out          = pix_valid_out & head[DATA_W];
  assign pix_sof_out          = pix_valid_out & head[DATA_W+1];
  assign frame_width_out      = width_q;
  assign frame_height_out     = height_q;
  assign frame_info_valid_out = info_q;
  assign overflow_cnt_out     = ovf_q;
  assign locked_out           = locked_q;

  always_comb begin
    data_s1_d   = hdmi_data;
    vs_s1_d     = VS_POL ? hdmi_vs : ~hdmi_vs;
    de_s1_d     = hdmi_de;
    hs_unused_d = hdmi_hs;
    vs_prev_d   = vs_s1_q;
    data_s2_d   = data_s1_q;
    pv_s2_d     = pv_s1;

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !rd_en) cnt_d = cnt_q + 1'b1;
    else if (!wr_en && rd_en) cnt_d = cnt_q - 1'b1;

    sof_pend_d = sof_pend_q;
    if (wr_en) sof_pend_d = 1'b0;
    if (vs_edge) sof_pend_d = 1'b1;

    pix_cnt_n  = pix_cnt_q;
    line_w_n   = line_w_q;
    line_cnt_n = line_cnt_q;
    if (wr_try) begin
      if (!pv_s1) begin
        line_w_n   = sat_inc(pix_cnt_q);
        line_cnt_n = sat_inc(line_cnt_q);
        pix_cnt_n  = '0;
      end else begin
        pix_cnt_n = sat_inc(pix_cnt_q);
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_in) state_d = WAIT_VS;
      WAIT_VS: if (vs_edge) state_d = enable_in ? ACTIVE : IDLE;
      default: begin
        if (vs_edge) state_d = enable_in ? ACTIVE : IDLE;
        else if (ovf_evt) state_d = DROP;
      end
    endcase

    // Measurements live only inside an intact active frame.
    if (state_q == ACTIVE && !vs_edge && !ovf_evt) begin
      pix_cnt_d  = pix_cnt_n;
      line_w_d   = line_w_n;
      line_cnt_d = line_cnt_n;
    end else begin
      pix_cnt_d  = '0;
      line_w_d   = '0;
      line_cnt_d = '0;
    end

    width_d   = width_q;
    height_d  = height_q;
    info_d    = 1'b0;
    locked_d  = locked_q;
    ref_vld_d = ref_vld_q;
    if (vs_edge && state_q == ACTIVE && !ovf_evt && line_cnt_n != '0) begin
      width_d   = line_w_n;
      height_d  = line_cnt_n;
      info_d    = 1'b1;
      locked_d  = ref_vld_q && (line_w_n == width_q) && (line_cnt_n == height_q);
      ref_vld_d = 1'b1;
    end
    if (ovf_evt || state_d == IDLE) begin
      locked_d  = 1'b0;
      ref_vld_d = 1'b0;
    end

    ovf_d = (ovf_evt && ovf_q != 16'hFFFF) ? ovf_q + 1'b1 : ovf_q;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      vs_s1_q     <= 1'b0;
      vs_prev_q   <= 1'b0;
      de_s1_q     <= 1'b0;
      hs_unused_q <= 1'b0;
      pv_s2_q     <= 1'b0;
      sof_pend_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pix_cnt_q   <= '0;
      line_w_q    <= '0;
      line_cnt_q  <= '0;
      width_q     <= '0;
      height_q    <= '0;
      info_q      <= 1'b0;
      locked_q    <= 1'b0;
      ref_vld_q   <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      vs_s1_q     <= vs_s1_d;
      vs_prev_q   <= vs_prev_d;
      de_s1_q     <= de_s1_d;
      hs_unused_q <= hs_unused_d;
      pv_s2_q     <= pv_s2_d;
      sof_pend_q  <= sof_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_w_q    <= line_w_d;
      line_cnt_q  <= line_cnt_d;
      width_q     <= width_d;
      height_q    <= height_d;
      info_q      <= info_d;
      locked_q    <= locked_d;
      ref_vld_q   <= ref_vld_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_hdmi_video_capture.sv
// Directed bench: frame table plus hand sequences for overflow, reset and VS polarity.
// A second instance with active-low VS sees the inverted vsync and must match the first.
module tb_hdmi_video_capture;

  logic        clk = 1'b0;
  logic        rst, hs, vs, de, en, rdy;
  logic        vs_n;
  logic [23:0] data;

  logic [23:0] o1_data, o2_data;
  logic        o1_sof, o1_eol, o1_valid, o1_info, o1_lock;
  logic        o2_sof, o2_eol, o2_valid, o2_info, o2_lock;
  logic [11:0] o1_w, o1_h, o2_w, o2_h;
  logic [15:0] o1_ovf, o2_ovf;

  assign vs_n = ~vs;
  always #5 clk = ~clk;

  hdmi_video_capture #(.VS_POL(1'b1)) dut1 (
    .clk_in(clk), .rst_in(rst), .hdmi_data(data), .hdmi_hs(hs), .hdmi_vs(vs), .hdmi_de(de),
    .enable_in(en), .pix_data_out(o1_data), .pix_sof_out(o1_sof), .pix_eol_out(o1_eol),
    .pix_valid_out(o1_valid), .pix_ready_in(rdy), .frame_width_out(o1_w),
    .frame_height_out(o1_h), .frame_info_valid_out(o1_info), .overflow_cnt_out(o1_ovf),
    .locked_out(o1_lock));

  hdmi_video_capture #(.VS_POL(1'b0)) dut2 (
    .clk_in(clk), .rst_in(rst), .hdmi_data(data), .hdmi_hs(hs), .hdmi_vs(vs_n), .hdmi_de(de),
    .enable_in(en), .pix_data_out(o2_data), .pix_sof_out(o2_sof), .pix_eol_out(o2_eol),
    .pix_valid_out(o2_valid), .pix_ready_in(rdy), .frame_width_out(o2_w),
    .frame_height_out(o2_h), .frame_info_valid_out(o2_info), .overflow_cnt_out(o2_ovf),
    .locked_out(o2_lock));

  typedef struct { logic [23:0] d; logic sof; logic eol; } beat_t;
  typedef struct {
    int w; int h; bit en; int drop_line; bit cap;
    int exp_info; int exp_w; int exp_h; bit exp_lock;
  } frame_vec_t;

  beat_t exp_q[$], act1[$], act2[$];
  int    n_chk = 0, n_pass = 0;
  int    info1 = 0;
  int    pix_val = 1;

  always @(negedge clk) begin
    if (!rst && o1_valid && rdy) act1.push_back(beat_t'{o1_data, o1_sof, o1_eol});
    if (!rst && o2_valid && rdy) act2.push_back(beat_t'{o2_data, o2_sof, o2_eol});
    if (o1_info) info1++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vs_pulse(input bit de_in);
    vs = 1'b1;
    hs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      de   = de_in;
      data = 24'hAA0000 | 24'(k);
      step();
    end
    vs = 1'b0; hs = 1'b0; de = 1'b0; data = '0;
    idle(3);
  endtask

  task automatic send_lines(input int w, input int h, input int drop_line, input bit cap);
    for (int l = 0; l < h; l++) begin
      if (l == drop_line) en = 1'b0;
      for (int p = 0; p < w; p++) begin
        de   = 1'b1;
        data = pix_val[23:0];
        if (cap) exp_q.push_back(beat_t'{pix_val[23:0], (l == 0 && p == 0), (p == w - 1)});
        pix_val++;
        step();
      end
      de = 1'b0; data = '0;
      idle(3);
    end
  endtask

  task automatic cmp_beats(input string nm);
    chk({nm, "_count1"}, 32'(act1.size()), 32'(exp_q.size()));
    chk({nm, "_count2"}, 32'(act2.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act1.size())
        chk($sformatf("%s_beat%0d_vspos", nm, i),
            32'({act1[i].sof, act1[i].eol, act1[i].d}), 32'({exp_q[i].sof, exp_q[i].eol, exp_q[i].d}));
      if (i < act2.size())
        chk($sformatf("%s_beat%0d_vsneg", nm, i),
            32'({act2[i].sof, act2[i].eol, act2[i].d}), 32'({exp_q[i].sof, exp_q[i].eol, exp_q[i].d}));
    end
    exp_q.delete();
    act1.delete();
    act2.delete();
  endtask

  frame_vec_t vecs [6];
  int base;

  initial begin
    //          w  h  en drop cap info ew eh lock
    vecs[0] = '{4, 3, 1, -1,  1,  1,   4, 3, 0};
    vecs[1] = '{4, 3, 1, -1,  1,  1,   4, 3, 1};
    vecs[2] = '{5, 3, 1, -1,  1,  1,   5, 3, 0};
    vecs[3] = '{5, 3, 1, -1,  1,  1,   5, 3, 1};
    vecs[4] = '{4, 3, 1,  1,  1,  1,   4, 3, 0};
    vecs[5] = '{4, 3, 0, -1,  0,  0,   4, 3, 0};

    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; en = 1'b0; rdy = 1'b1; data = '0;
    idle(3);
    chk("reset_valid", 32'(o1_valid), 0);
    chk("reset_data", 32'(o1_data), 0);
    chk("reset_dims", 32'({o1_w, o1_h}), 0);
    chk("reset_ovf", 32'(o1_ovf), 0);
    chk("reset_lock_info", 32'({o1_lock, o1_info}), 0);
    rst = 1'b0;
    en  = 1'b1;
    step();
    vs_pulse(1'b0);

    for (int r = 0; r < 6; r++) begin
      en      = vecs[r].en;
      pix_val = 1;
      base    = info1;
      send_lines(vecs[r].w, vecs[r].h, vecs[r].drop_line, vecs[r].cap);
      vs_pulse(1'b0);
      idle(8);
      cmp_beats($sformatf("row%0d", r));
      chk($sformatf("row%0d_info", r), 32'(info1 - base), 32'(vecs[r].exp_info));
      chk($sformatf("row%0d_width", r), 32'(o1_w), 32'(vecs[r].exp_w));
      chk($sformatf("row%0d_height", r), 32'(o1_h), 32'(vecs[r].exp_h));
      chk($sformatf("row%0d_locked", r), 32'(o1_lock), 32'(vecs[r].exp_lock));
    end

    // Overflow: stalled sink, 32-pixel line into a 16-deep FIFO.
    en = 1'b1; rdy = 1'b0;
    step();
    vs_pulse(1'b0);
    pix_val = 1;
    base    = info1;
    send_lines(32, 1, -1, 1'b0);
    for (int i = 1; i <= 16; i++) exp_q.push_back(beat_t'{24'(i), (i == 1), 1'b0});
    chk("ovf_count", 32'(o1_ovf), 1);
    chk("ovf_head", 32'({o1_valid, o1_sof, o1_eol, o1_data}), 32'({3'b110, 24'd1}));
    idle(5);
    chk("ovf_stall_hold", 32'({o1_valid, o1_sof, o1_data}), 32'({2'b11, 24'd1}));
    vs_pulse(1'b0);
    idle(2);
    chk("ovf_no_info", 32'(info1 - base), 0);
    rdy = 1'b1;
    idle(20);
    cmp_beats("ovf_drain");
    base    = info1;
    pix_val = 100;
    send_lines(4, 1, -1, 1'b1);
    vs_pulse(1'b0);
    idle(8);
    cmp_beats("post_ovf");
    chk("post_ovf_info", 32'(info1 - base), 1);
    chk("post_ovf_dims", 32'({o1_w, o1_h}), 32'({12'd4, 12'd1}));
    chk("post_ovf_ovf", 32'(o1_ovf), 1);
    chk("post_ovf_locked", 32'(o1_lock), 0);

    // Reset mid-line with pixels sitting in the FIFO.
    rdy = 1'b0;
    pix_val = 200;
    for (int i = 0; i < 7; i++) begin
      de = 1'b1; data = pix_val[23:0]; pix_val++;
      step();
    end
    chk("pre_rst_valid", 32'(o1_valid), 1);
    rst = 1'b1;
    step();
    chk("rst_valid", 32'(o1_valid), 0);
    chk("rst_stream", 32'({o1_sof, o1_eol, o1_data}), 0);
    chk("rst_dims", 32'({o1_w, o1_h}), 0);
    chk("rst_ovf", 32'(o1_ovf), 0);
    chk("rst_lock_info", 32'({o1_lock, o1_info}), 0);
    rst = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = pix_val[23:0]; pix_val++;
      step();
    end
    de = 1'b0; data = '0;
    idle(8);
    cmp_beats("rst_no_vs");
    vs_pulse(1'b0);
    pix_val = 1;
    base    = info1;
    send_lines(4, 1, -1, 1'b1);
    vs_pulse(1'b0);
    idle(8);
    cmp_beats("rst_resume");
    chk("rst_resume_info", 32'(info1 - base), 1);
    chk("rst_resume_dims", 32'({o1_w, o1_h}), 32'({12'd4, 12'd1}));

    // DE asserted during VS must never reach the stream, for either polarity.
    pix_val = 1;
    base    = info1;
    vs_pulse(1'b1);
    send_lines(4, 2, -1, 1'b1);
    vs_pulse(1'b1);
    idle(8);
    cmp_beats("de_in_vs");
    chk("de_in_vs_dims", 32'({o1_w, o1_h}), 32'({12'd4, 12'd2}));
    chk("de_in_vs_dims_vsneg", 32'({o2_w, o2_h}), 32'({12'd4, 12'd2}));
    chk("de_in_vs_info", 32'(info1 - base), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
